// File: rtl/mb_crc_link_ctrl_if.sv
// Link bundle between the host word source / CRC register and the
// serial CRC link transmit sequencer.
interface mb_crc_link_ctrl_if #(
  parameter int DATA_W = 8
);
  logic [DATA_W-1:0] tx_data;
  logic              tx_valid;
  logic              tx_ready;
  logic              ser_out;
  logic              frame;
  logic              done;
  logic              crc_clr;
  logic              crc_en;
  logic              crc_mode;
  logic              crc_din;
  logic              crc_in;

  // Environment side: word source plus external CRC register output.
  modport master (
    output tx_data, tx_valid, crc_in,
    input  tx_ready, ser_out, frame, done, crc_clr, crc_en, crc_mode, crc_din
  );

  // Sequencer side.
  modport slave (
    input  tx_data, tx_valid, crc_in,
    output tx_ready, ser_out, frame, done, crc_clr, crc_en, crc_mode, crc_din
  );
endinterface

// File: rtl/mb_crc_link_ctrl.sv
// Transmit sequencer for the serial CRC link: accepts a word, then sends
// start bit, data MSB first, CRC field (from the external CRC register),
// and stop bit, strobing the CRC register as it goes.
module mb_crc_link_ctrl #(
  parameter int DATA_W  = 8,
  parameter int CRC_W   = 4,
  parameter int BIT_CYC = 4
) (
  input  logic             CLK,
  input  logic             CLR,
  mb_crc_link_ctrl_if.slave link
);

  localparam int CYC_W = (BIT_CYC > 1) ? $clog2(BIT_CYC) : 1;
  localparam int IDX_N = (DATA_W > CRC_W) ? DATA_W : CRC_W;
  localparam int IDX_W = (IDX_N > 1) ? $clog2(IDX_N) : 1;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    START,
    DATA,
    CRC,
    STOP
  } state_t;

  state_t             state;
  state_t             state_next;
  logic [CYC_W-1:0]   cyc_cnt;
  logic [IDX_W-1:0]   bit_idx;
  logic [DATA_W-1:0]  shreg;
  logic               last_cyc;
  logic               accept;

  assign last_cyc = (cyc_cnt == CYC_W'(BIT_CYC - 1));
  assign accept   = (state == IDLE) && link.tx_valid;

  // State register; reset drops straight back to IDLE so the line idles at once.
  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) state <= IDLE;
    else     state <= state_next;
  end

  // Bit-cycle counter restarts on every state entry and at the end of each bit.
  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR)
      cyc_cnt <= '0;
    else if (state == IDLE || state == CLEAR || state_next != state || last_cyc)
      cyc_cnt <= '0;
    else
      cyc_cnt <= cyc_cnt + CYC_W'(1);
  end

  // Bit index walks the data field and then the CRC field, reset on each entry.
  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR)
      bit_idx <= '0;
    else if (state_next != state)
      bit_idx <= '0;
    else if ((state == DATA || state == CRC) && last_cyc)
      bit_idx <= bit_idx + IDX_W'(1);
  end

  // Word is captured at accept and shifted left as each data bit completes.
  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR)
      shreg <= '0;
    else if (accept)
      shreg <= link.tx_data;
    else if (state == DATA && last_cyc)
      shreg <= shreg << 1;
  end

  // Next-state and all outputs decoded from the current state and counters.
  always_comb begin
    state_next    = state;
    link.tx_ready = 1'b0;
    link.ser_out  = 1'b1;
    link.frame    = 1'b0;
    link.done     = 1'b0;
    link.crc_clr  = 1'b0;
    link.crc_en   = 1'b0;
    link.crc_mode = 1'b0;
    link.crc_din  = 1'b0;
    case (state)
      IDLE: begin
        link.tx_ready = 1'b1;
        if (link.tx_valid) state_next = CLEAR;
      end
      CLEAR: begin
        link.crc_clr = 1'b1;
        state_next   = START;
      end
      START: begin
        link.ser_out = 1'b0;
        link.frame   = 1'b1;
        if (last_cyc) state_next = DATA;
      end
      DATA: begin
        link.ser_out = shreg[DATA_W-1];
        link.crc_din = shreg[DATA_W-1];
        link.frame   = 1'b1;
        link.crc_en  = last_cyc;
        if (last_cyc && bit_idx == IDX_W'(DATA_W - 1)) state_next = CRC;
      end
      CRC: begin
        link.ser_out  = link.crc_in;
        link.crc_mode = 1'b1;
        link.frame    = 1'b1;
        link.crc_en   = last_cyc;
        if (last_cyc && bit_idx == IDX_W'(CRC_W - 1)) state_next = STOP;
      end
      STOP: begin
        link.frame = 1'b1;
        link.done  = last_cyc;
        if (last_cyc) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_mb_crc_link_ctrl.sv
// Self-checking bench for mb_crc_link_ctrl: three instances with different
// widths/bit stretch, each paired with a behavioural CRC register, checked
// cycle by cycle against a frame model built from the word and its CRC.
module tb_mb_crc_link_ctrl;

  logic       CLK = 1'b0;
  logic       CLR = 1'b1;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  int         sel = 0;

  int checks = 0;
  int errors = 0;
  int accepts [3] = '{0, 0, 0};
  int exp_accepts [3] = '{0, 0, 0};

  mb_crc_link_ctrl_if #(.DATA_W(8)) lnk0 ();
  mb_crc_link_ctrl_if #(.DATA_W(8)) lnk1 ();
  mb_crc_link_ctrl_if #(.DATA_W(1)) lnk2 ();

  mb_crc_link_ctrl #(.DATA_W(8), .CRC_W(4), .BIT_CYC(4)) u0 (.CLK(CLK), .CLR(CLR), .link(lnk0));
  mb_crc_link_ctrl #(.DATA_W(8), .CRC_W(4), .BIT_CYC(1)) u1 (.CLK(CLK), .CLR(CLR), .link(lnk1));
  mb_crc_link_ctrl #(.DATA_W(1), .CRC_W(1), .BIT_CYC(1)) u2 (.CLK(CLK), .CLR(CLR), .link(lnk2));

  always #5 CLK = ~CLK;

  // External CRC registers (x^4+x+1 for the 4-bit links, x+1 for the 1-bit link).
  logic [3:0] crc_reg0 = 4'h0;
  logic [3:0] crc_reg1 = 4'h0;
  logic       crc_reg2 = 1'b0;

  assign lnk0.tx_data  = tx_data;
  assign lnk1.tx_data  = tx_data;
  assign lnk2.tx_data  = tx_data[0];
  assign lnk0.tx_valid = tx_valid && (sel == 0);
  assign lnk1.tx_valid = tx_valid && (sel == 1);
  assign lnk2.tx_valid = tx_valid && (sel == 2);
  assign lnk0.crc_in   = crc_reg0[3];
  assign lnk1.crc_in   = crc_reg1[3];
  assign lnk2.crc_in   = crc_reg2;

  // Behavioural CRC registers reacting to the controller's strobes.
  always @(posedge CLK) begin
    if (lnk0.crc_clr) crc_reg0 <= 4'h0;
    else if (lnk0.crc_en)
      crc_reg0 <= lnk0.crc_mode ? {crc_reg0[2:0], 1'b0}
                                : ({crc_reg0[2:0], 1'b0} ^ {2'b00, {2{crc_reg0[3] ^ lnk0.crc_din}}});
    if (lnk1.crc_clr) crc_reg1 <= 4'h0;
    else if (lnk1.crc_en)
      crc_reg1 <= lnk1.crc_mode ? {crc_reg1[2:0], 1'b0}
                                : ({crc_reg1[2:0], 1'b0} ^ {2'b00, {2{crc_reg1[3] ^ lnk1.crc_din}}});
    if (lnk2.crc_clr) crc_reg2 <= 1'b0;
    else if (lnk2.crc_en)
      crc_reg2 <= lnk2.crc_mode ? 1'b0 : (crc_reg2 ^ lnk2.crc_din);
  end

  // Handshake monitor counting accepted words per link.
  always @(posedge CLK) begin
    if (lnk0.tx_valid && lnk0.tx_ready) accepts[0] <= accepts[0] + 1;
    if (lnk1.tx_valid && lnk1.tx_ready) accepts[1] <= accepts[1] + 1;
    if (lnk2.tx_valid && lnk2.tx_ready) accepts[2] <= accepts[2] + 1;
  end

  // Observation mux onto the link currently under test.
  logic o_ready, o_ser, o_frame, o_done, o_clr, o_en, o_mode, o_din;
  always_comb begin
    {o_ready, o_ser, o_frame, o_done, o_clr, o_en, o_mode, o_din} = '0;
    case (sel)
      0: {o_ready, o_ser, o_frame, o_done, o_clr, o_en, o_mode, o_din} =
           {lnk0.tx_ready, lnk0.ser_out, lnk0.frame, lnk0.done, lnk0.crc_clr, lnk0.crc_en, lnk0.crc_mode, lnk0.crc_din};
      1: {o_ready, o_ser, o_frame, o_done, o_clr, o_en, o_mode, o_din} =
           {lnk1.tx_ready, lnk1.ser_out, lnk1.frame, lnk1.done, lnk1.crc_clr, lnk1.crc_en, lnk1.crc_mode, lnk1.crc_din};
      default: {o_ready, o_ser, o_frame, o_done, o_clr, o_en, o_mode, o_din} =
           {lnk2.tx_ready, lnk2.ser_out, lnk2.frame, lnk2.done, lnk2.crc_clr, lnk2.crc_en, lnk2.crc_mode, lnk2.crc_din};
    endcase
  end

  function automatic int dw_of(input int inst);
    return (inst == 2) ? 1 : 8;
  endfunction
  function automatic int cw_of(input int inst);
    return (inst == 2) ? 1 : 4;
  endfunction
  function automatic int bc_of(input int inst);
    return (inst == 0) ? 4 : 1;
  endfunction

  // Reference CRC: polynomial division of the data bits, MSB first.
  function automatic int crc_ref(input logic [7:0] w, input int dw, input int cw);
    int c, mask, poly, fb;
    c    = 0;
    mask = (1 << cw) - 1;
    poly = (cw == 4) ? 3 : 1;
    for (int i = dw - 1; i >= 0; i--) begin
      fb = ((c >> (cw - 1)) & 1) ^ int'(w[i]);
      c  = (c << 1) & mask;
      if (fb != 0) c = c ^ poly;
    end
    return c;
  endfunction

  task automatic checkOutput(input string tag, input int observed, input int expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s observed=%0d expected=%0d at %0t", tag, observed, expected, $time);
    end
  endtask

  task automatic checkIdleLevels(input string tag);
    checkOutput({tag, " tx_ready"}, int'(o_ready), 1);
    checkOutput({tag, " ser_out"},  int'(o_ser),   1);
    checkOutput({tag, " frame"},    int'(o_frame), 0);
    checkOutput({tag, " done"},     int'(o_done),  0);
    checkOutput({tag, " crc_en"},   int'(o_en),    0);
    checkOutput({tag, " crc_mode"}, int'(o_mode),  0);
  endtask

  // Sends one word on a link (called at a sample point with the link in IDLE)
  // and checks every cycle from CLEAR through the following IDLE cycle.
  task automatic applyStimulus(input int inst, input logic [7:0] word,
                               input bit hold_next, input logic [7:0] next_word);
    int dw, cw, bc, n, slot, phase, en_count, crc;
    logic [7:0] w;
    int e_ser, e_frame, e_done, e_clr, e_en, e_mode, e_din;
    dw  = dw_of(inst);
    cw  = cw_of(inst);
    bc  = bc_of(inst);
    w   = word & 8'((1 << dw) - 1);
    crc = crc_ref(w, dw, cw);
    n   = (dw + cw + 2) * bc;
    sel      = inst;
    tx_data  = word;
    tx_valid = 1'b1;
    exp_accepts[inst]++;
    @(posedge CLK); #1;
    en_count = 0;
    for (int k = 0; k <= n; k++) begin
      e_ser = 1; e_frame = 0; e_done = 0; e_clr = 0; e_en = 0; e_mode = 0; e_din = 0;
      if (k == 0) begin
        e_clr = 1;
      end else begin
        slot    = (k - 1) / bc;
        phase   = (k - 1) % bc;
        e_frame = 1;
        if (slot == 0) begin
          e_ser = 0;
        end else if (slot <= dw) begin
          e_ser = int'(w[dw - slot]);
          e_din = e_ser;
          e_en  = (phase == bc - 1) ? 1 : 0;
        end else if (slot <= dw + cw) begin
          e_ser  = (crc >> (cw - 1 - (slot - dw - 1))) & 1;
          e_mode = 1;
          e_en   = (phase == bc - 1) ? 1 : 0;
        end else begin
          e_done = (k == n) ? 1 : 0;
        end
      end
      checkOutput($sformatf("L%0d c%0d ser_out", inst, k),  int'(o_ser),   e_ser);
      checkOutput($sformatf("L%0d c%0d frame", inst, k),    int'(o_frame), e_frame);
      checkOutput($sformatf("L%0d c%0d done", inst, k),     int'(o_done),  e_done);
      checkOutput($sformatf("L%0d c%0d crc_clr", inst, k),  int'(o_clr),   e_clr);
      checkOutput($sformatf("L%0d c%0d crc_en", inst, k),   int'(o_en),    e_en);
      checkOutput($sformatf("L%0d c%0d crc_mode", inst, k), int'(o_mode),  e_mode);
      checkOutput($sformatf("L%0d c%0d crc_din", inst, k),  int'(o_din),   e_din);
      checkOutput($sformatf("L%0d c%0d tx_ready", inst, k), int'(o_ready), 0);
      en_count += int'(o_en);
      tx_data = 8'($urandom);
      if (!hold_next) tx_valid = 1'($urandom_range(0, 1));
      @(posedge CLK); #1;
    end
    checkOutput($sformatf("L%0d crc_en count", inst), en_count, dw + cw);
    checkIdleLevels($sformatf("L%0d gap", inst));
    checkOutput($sformatf("L%0d gap crc_clr", inst), int'(o_clr), 0);
    if (hold_next) tx_data = next_word;
    else           tx_valid = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int         inst;
    bit         chain, pending;
    logic [7:0] word, next_w, pending_w;

    // Reset levels on every link while CLR is held.
    repeat (2) @(posedge CLK);
    #1;
    for (int i = 0; i < 3; i++) begin
      sel = i;
      #0;
      checkIdleLevels($sformatf("reset L%0d", i));
      checkOutput($sformatf("reset L%0d crc_clr", i), int'(o_clr), 0);
      checkOutput($sformatf("reset L%0d crc_din", i), int'(o_din), 0);
    end
    sel = 0;
    CLR = 1'b0;

    // Directed frames: defaults at one cycle per bit, stretched 0xFF, chained pair, minimum widths.
    applyStimulus(1, 8'hA5, 1'b0, 8'h00);
    applyStimulus(0, 8'hFF, 1'b0, 8'h00);
    applyStimulus(0, 8'h01, 1'b1, 8'h80);
    applyStimulus(0, 8'h80, 1'b0, 8'h00);
    applyStimulus(2, 8'h01, 1'b0, 8'h00);
    applyStimulus(2, 8'h00, 1'b0, 8'h00);

    // Asynchronous reset in the middle of the data field, then a clean frame.
    sel      = 0;
    tx_data  = 8'hC3;
    tx_valid = 1'b1;
    exp_accepts[0]++;
    @(posedge CLK); #1;
    tx_valid = 1'b0;
    repeat (1 + 4 + 4 * 2 + 1) @(posedge CLK);
    #3;
    checkOutput("pre-abort frame", int'(o_frame), 1);
    CLR = 1'b1;
    #1;
    checkIdleLevels("abort");
    @(posedge CLK); #1;
    checkIdleLevels("abort held");
    CLR = 1'b0;
    applyStimulus(0, 8'h3C, 1'b0, 8'h00);

    // Randomized frames, optionally chained with tx_valid held.
    pending   = 1'b0;
    pending_w = 8'h00;
    inst      = 0;
    for (int i = 0; i < 12; i++) begin
      if (pending) word = pending_w;
      else begin
        inst = $urandom_range(0, 2);
        word = 8'($urandom);
      end
      chain  = (i == 11) ? 1'b0 : 1'($urandom_range(0, 1));
      next_w = 8'($urandom);
      applyStimulus(inst, word, chain, next_w);
      pending   = chain;
      pending_w = next_w;
    end

    repeat (3) @(posedge CLK);
    #1;
    for (int i = 0; i < 3; i++)
      checkOutput($sformatf("L%0d accept count", i), accepts[i], exp_accepts[i]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
